// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MARK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection; ARB_ROUND_ROBIN_EN adds a last-grant flag.
module mem_arb_pick import mem_arb_pkg::*; (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

`ifdef ARB_ROUND_ROBIN_EN
  // prefer_i_q is set once data has won, so the instruction side gets the next tie.
  logic prefer_i_q;
  logic prefer_i_d;

  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    prefer_i_d = prefer_i_q;
    if (idle) begin
      if (i_valid && d_valid) begin
        grant_i = prefer_i_q;
        grant_d = !prefer_i_q;
      end else begin
        grant_i = i_valid;
        grant_d = d_valid;
      end
    end
    if (grant_d) begin
      prefer_i_d = 1'b1;
    end else if (grant_i) begin
      prefer_i_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prefer_i_q <= 1'b0;
    end else begin
      prefer_i_q <= prefer_i_d;
    end
  end
`else
  logic unused_clock_reset;
  assign unused_clock_reset = clock ^ reset;

  always_comb begin
    grant_d = idle && d_valid;
    grant_i = idle && i_valid && !d_valid;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto one memory port; ARB_ROUND_ROBIN_EN selects round-robin ties.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MARK_W = DEF_MARK_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [MARK_W-1:0] d_req_mark,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_readEn,
  output logic              mem_writeEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic [MARK_W-1:0] mem_mark,
  input  logic [DATA_W-1:0] mem_readData
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       store_q;
  logic       store_d;
  logic       idle;
  logic       grant_i;
  logic       grant_d;

  // Gating with reset keeps every output low while reset is held, even with valids up.
  assign idle = (state_q == IDLE) && !reset;

  mem_arb_pick u_pick (
    .clock   (clock),
    .reset   (reset),
    .idle    (idle),
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    i_resp_valid  = 1'b0;
    i_resp_data   = '0;
    d_resp_valid  = 1'b0;
    d_resp_data   = '0;
    mem_readEn    = 1'b0;
    mem_writeEn   = 1'b0;
    mem_addr      = '0;
    mem_writeData = '0;
    mem_mark      = '0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          d_req_ready   = 1'b1;
          mem_addr      = d_req_addr;
          mem_mark      = d_req_mark;
          mem_writeEn   = d_req_write;
          mem_readEn    = !d_req_write;
          mem_writeData = d_req_write ? d_req_wdata : '0;
          store_d       = d_req_write;
          state_d       = GRANT_D;
        end else if (grant_i) begin
          i_req_ready = 1'b1;
          mem_addr    = i_req_addr;
          mem_mark    = '1;
          mem_readEn  = 1'b1;
          store_d     = 1'b0;
          state_d     = GRANT_I;
        end
      end
      GRANT_I: begin
        i_resp_valid = 1'b1;
        i_resp_data  = mem_readData;
        state_d      = IDLE;
      end
      GRANT_D: begin
        d_resp_valid = 1'b1;
        d_resp_data  = store_q ? '0 : mem_readData;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with response scoreboard and behavioural memory.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_write;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_mark;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_readEn;
  logic        mem_writeEn;
  logic [31:0] mem_addr;
  logic [31:0] mem_writeData;
  logic [3:0]  mem_mark;
  logic [31:0] mem_readData = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MARK_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .i_req_valid   (i_req_valid),
    .i_req_ready   (i_req_ready),
    .i_req_addr    (i_req_addr),
    .i_resp_valid  (i_resp_valid),
    .i_resp_data   (i_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_write   (d_req_write),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_mark    (d_req_mark),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_readEn    (mem_readEn),
    .mem_writeEn   (mem_writeEn),
    .mem_addr      (mem_addr),
    .mem_writeData (mem_writeData),
    .mem_mark      (mem_mark),
    .mem_readData  (mem_readData)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] mark);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mark[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word-addressed memory behind the shared port; read data appears the cycle after the strobe.
  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        preload;

  always @(posedge clock) begin
    if (preload) begin
      for (int k = 0; k < 4096; k++) mem[k] <= '0;
      mem[0] <= 32'h0000_0413;
    end else begin
      if (mem_writeEn) mem[mem_addr[13:2]] <= merge(mem[mem_addr[13:2]], mem_writeData, mem_mark);
      if (mem_readEn) mem_readData <= mem[mem_addr[13:2]];
    end
  end

  task automatic check_resp(input logic is_d, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk(is_d ? "d_resp_unexpected" : "i_resp_unexpected", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("resp_side", {63'd0, is_d}, {63'd0, e.is_d});
      chk("resp_data", {32'd0, data}, {32'd0, e.data});
      chk("resp_latency", cyc, e.cyc + 1);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (i_resp_valid) check_resp(1'b0, i_resp_data);
      if (d_resp_valid) check_resp(1'b1, d_resp_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_i(input logic [31:0] addr, output int waited);
    waited = 0;
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    @(negedge clock);
    while (!i_req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("i_ready_seen", {63'd0, i_req_ready}, 64'd1);
    if (i_req_ready) begin
      chk("i_strobes", {62'd0, mem_readEn, mem_writeEn}, 64'b10);
      chk("i_mem_addr", {32'd0, mem_addr}, {32'd0, addr});
      chk("i_mem_mark", {60'd0, mem_mark}, 64'hf);
      sb.push_back('{1'b0, ref_mem[addr[13:2]], cyc});
    end
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic issue_d(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] mark, output int waited);
    waited = 0;
    d_req_valid = 1'b1;
    d_req_write = wr;
    d_req_addr  = addr;
    d_req_wdata = wd;
    d_req_mark  = mark;
    @(negedge clock);
    while (!d_req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("d_ready_seen", {63'd0, d_req_ready}, 64'd1);
    if (d_req_ready) begin
      chk("d_strobes", {62'd0, mem_readEn, mem_writeEn}, wr ? 64'b01 : 64'b10);
      chk("d_mem_addr", {32'd0, mem_addr}, {32'd0, addr});
      chk("d_mem_mark", {60'd0, mem_mark}, {60'd0, mark});
      if (wr) chk("d_mem_wdata", {32'd0, mem_writeData}, {32'd0, wd});
      sb.push_back('{1'b1, wr ? 32'd0 : ref_mem[addr[13:2]], cyc});
      if (wr) ref_mem[addr[13:2]] = merge(ref_mem[addr[13:2]], wd, mark);
    end
    tick();
    d_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  waited;
    logic exp_d;
    logic pref_i;
    reset       = 1'b1;
    preload     = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h8000_0000;
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 32'h8000_1000;
    d_req_wdata = '0;
    d_req_mark  = '0;
    for (int k = 0; k < 4096; k++) ref_mem[k] = '0;
    ref_mem[0] = 32'h0000_0413;

    // Reset holds everything low even with both valids raised.
    @(negedge clock);
    preload = 1'b0;
    chk("rst_readies", {62'd0, i_req_ready, d_req_ready}, 64'd0);
    chk("rst_strobes", {62'd0, mem_readEn, mem_writeEn}, 64'd0);
    chk("rst_resp", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk("rst_mem_cmd", {mem_addr, mem_mark, 28'd0}, 64'd0);
    d_req_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Lone fetch, accepted in the first cycle after reset.
    issue_i(32'h8000_0000, waited);
    chk("first_accept_wait", waited, 0);

    // Masked store, then readback of the partially written word.
    issue_d(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3, waited);
    issue_d(1'b0, 32'h8000_1000, 32'h0, 4'hf, waited);
    chk("store_back_to_back_wait", waited, 1);
    issue_d(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hf, waited);
    issue_i(32'h8000_0010, waited);
    repeat (2) tick();

    // Contention: both sides held; flag restarts at 0 after reset.
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 32'h8000_1000;
    d_req_mark  = 4'hf;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h8000_0000;
    pref_i      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k % 2 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d  = !pref_i;
        pref_i = exp_d;
`else
        exp_d = 1'b1;
`endif
        chk($sformatf("contend_grant_c%0d", k), {62'd0, i_req_ready, d_req_ready},
            exp_d ? 64'b01 : 64'b10);
        sb.push_back('{exp_d, exp_d ? ref_mem[12'h400] : ref_mem[12'h000], cyc});
      end else begin
        chk($sformatf("contend_grant_c%0d", k), {62'd0, i_req_ready, d_req_ready}, 64'd0);
      end
    end
    tick();
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
    tick();

    // Reset during GRANT_D drops the pending response.
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 32'h8000_1000;
    @(negedge clock);
    chk("rstmid_accept", {63'd0, d_req_ready}, 64'd1);
    tick();
    reset       = 1'b1;
    d_req_valid = 1'b0;
    @(negedge clock);
    chk("rstmid_d_resp", {63'd0, d_resp_valid}, 64'd0);
    chk("rstmid_outputs", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid,
                           mem_readEn, mem_writeEn, mem_mark, d_resp_data, 22'd0}, 64'd0);
    tick();
    reset = 1'b0;
    issue_d(1'b0, 32'h8000_1000, 32'h0, 4'hf, waited);
    chk("rstmid_next_wait", waited, 0);

    // Instruction valid raised only during GRANT_D is withdrawn unserved.
    tick();
    issue_d(1'b0, 32'h8000_0010, 32'h0, 4'hf, waited);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h8000_0000;
    @(negedge clock);
    chk("wd_ready_in_grant", {62'd0, i_req_ready, mem_readEn}, 64'd0);
    tick();
    i_req_valid = 1'b0;
    @(negedge clock);
    chk("wd_idle_quiet", {60'd0, i_req_ready, mem_readEn, mem_writeEn, i_resp_valid}, 64'd0);
    tick();
    @(negedge clock);
    chk("wd_no_resp", {63'd0, i_resp_valid}, 64'd0);

    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; MARK_W, default 4, byte-mask width.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_req_valid  in  1  instruction-side request pending.
REQ-005 i_req_ready  out  1  instruction request accepted this cycle (when valid also high).
REQ-006 i_req_addr  in  ADDR_W  instruction fetch address; reads only.
REQ-007 i_resp_valid  out  1  one-cycle pulse: i_resp_data valid.
REQ-008 i_resp_data  out  DATA_W  fetched word.
REQ-009 d_req_valid / d_req_ready  in / out  1 / 1  data-side handshake, same rules as instruction side.
REQ-010 d_req_write  in  1  1 = store, 0 = load.
REQ-011 d_req_addr / d_req_wdata / d_req_mark  in  ADDR_W / DATA_W / MARK_W  data address, store data, byte mask.
REQ-012 d_resp_valid / d_resp_data  out  1 / DATA_W  pulse for every accepted data request, including stores; data is 0 for stores.
REQ-013 mem_readEn / mem_writeEn  out  1 / 1  single shared memory port strobes.
REQ-014 mem_addr / mem_writeData / mem_mark  out  ADDR_W / DATA_W / MARK_W  shared port command.
REQ-015 mem_readData  in  DATA_W  read data, valid the cycle after the read strobe is sampled.

Function
REQ-016 The FSM SHALL have the states IDLE, GRANT_I and GRANT_D; it SHALL return to IDLE on reset.
REQ-017 In IDLE with at least one valid, the arbiter SHALL assert exactly one ready combinationally and drive the winner's command onto the mem_* port in the same cycle.
REQ-018 Loads and fetches SHALL assert only mem_readEn; stores SHALL assert only mem_writeEn; fetches SHALL drive mem_mark to all ones.
REQ-019 On acceptance, the FSM SHALL move to GRANT_I or GRANT_D; in that state the matching resp_valid SHALL be high for exactly 1 cycle, carrying mem_readData for reads. Latency: acceptance at N, response at N+1.
REQ-020 In GRANT_* states, both readies SHALL be 0 and the mem strobes SHALL be 0; the next acceptance SHALL happen no earlier than the IDLE cycle that follows. Peak throughput: 1 transaction per 2 cycles.
REQ-021 Requests SHALL NOT be registered; a requester SHALL hold valid and its payload stable until ready is seen, and the arbiter captures only the grant owner.
REQ-022 Simultaneous valids, default policy: data wins.
REQ-023 A valid that is dropped before ready SHALL be treated as withdrawn, with no memory access and no response.
REQ-024 Responses SHALL have no backpressure; the requester SHALL sample the response in the pulse cycle.
REQ-025 All mem_* outputs, resp data and readies SHALL be 0 whenever no grant is being issued.

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE and the priority flag to 0, and SHALL force every output to 0.
REQ-027 If reset asserts in a GRANT_* state, the pending response SHALL be dropped; a memory write already sampled before the reset is not undone.
REQ-028 The first acceptance SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-029 ARB_ROUND_ROBIN_EN defined: on simultaneous valids, the side that was not granted most recently SHALL win. A 1-bit last-grant flag updates on every acceptance and is 0 (data preferred) after reset.
REQ-030 ARB_ROUND_ROBIN_EN undefined: fixed priority (data over instruction) applies; the flag is absent.

Structure
REQ-031 A shared package mem_arb_pkg SHALL hold the state enum (IDLE, GRANT_I, GRANT_D) and the default width constants.
REQ-032 One sub-module, mem_arb_pick, SHALL contain the combinational winner selection, including the round-robin flag logic when enabled; the FSM and port muxing stay in the top module.

Verification
REQ-033 Lone fetch: i_req_valid=1, addr=0x80000000, memory holds 0x00000413 -> i_req_ready and mem_readEn at cycle N, i_resp_valid=1 with data 0x00000413 at N+1.
REQ-034 Store: d_req_write=1, addr=0x80001000, wdata=0xDEADBEEF, mark=0x3 -> mem_writeEn=1, mem_mark=0x3 at N; d_resp_valid=1 with data 0 at N+1; a later load of that address returns 0x0000BEEF for a zero-initialised word.
REQ-035 Contention, macro undefined: both valid and held for 6 cycles -> data is granted at cycles 0, 2 and 4; instruction is never granted.
REQ-036 Contention, ARB_ROUND_ROBIN_EN defined: both valid and held -> grants are D, I, D, I at cycles 0, 2, 4, 6.
REQ-037 Reset mid-transaction: assert reset in the GRANT_D cycle of a load -> d_resp_valid=0 immediately and all outputs 0; the next request after deassert completes with latency 1.
REQ-038 Withdrawal: i_req_valid high only during the GRANT_D cycle of a data load -> no fetch is issued and i_resp_valid stays 0.
